parity_gen: RTL and testbench
=============================

# parity_gen

Even-parity generator and checker for a W-bit data word. A purely combinational XOR-reduction output gives immediate parity. A registered stage adds validated parity, a parity-mismatch checker and a saturating error counter. It sits on datapath buses that need parity attached on transmit or verified on receive.

## Interface
Parameters:
- W, 16, data width in bits (legal range 1..64)
- CW, 8, error-counter width in bits (legal range 1..32)

Ports:
- clk  input  1  single clock; all registers update on its rising edge
- rst  input  1  asynchronous, active-high reset
- a  input  W  data word
- parity  output  1  combinational XOR of all bits of a
- in_valid  input  1  a (and parity_in) are sampled this cycle
- chk_en  input  1  when high with in_valid, compare parity_in against the computed parity
- parity_in  input  1  received parity bit to check
- clr  input  1  synchronous clear of err_cnt and err_sticky
- parity_q  output  1  registered parity of the last sampled word
- odd_q  output  1  registered odd parity (~parity_q)
- out_valid  output  1  parity_q / odd_q / err valid this cycle
- err  output  1  registered single-cycle mismatch flag
- err_sticky  output  1  set on any mismatch, held until clr or rst
- err_cnt  output  CW  saturating count of mismatches

## Operation
- parity = a[0] ^ a[1] ^ ... ^ a[W-1]; 1 when a has an odd number of ones. It has no dependence on clk or rst and must settle within one combinational path.
- X/Z on any bit of a may propagate to parity. No masking.
- On a clk edge with in_valid=1:
  - parity_q <= parity(a)
  - odd_q <= ~parity(a)
  - out_valid <= 1
  - err <= chk_en & (parity_in != parity(a))
- On a clk edge with in_valid=0: out_valid <= 0 and err <= 0. parity_q and odd_q hold their values.
- When a mismatch is registered (err next = 1):
  - err_sticky <= 1
  - err_cnt increments, saturating at 2^CW-1 (no wrap)
- clr=1: err_cnt <= 0 and err_sticky <= 0.
  - clr takes priority over a same-cycle mismatch: that mismatch is not counted and does not set err_sticky.
  - err itself still pulses for that mismatch.
- chk_en=0: no error is ever flagged. Parity is still registered.

## Timing
- parity: zero-cycle combinational latency from a.
- Registered outputs: 1-cycle latency. A word sampled at edge N appears on parity_q, odd_q, out_valid and err after edge N.
- Full throughput: a new word every cycle is accepted and no backpressure exists.
- Reset values (immediate on rst assertion, independent of clk): parity_q=0, odd_q=1, out_valid=0, err=0, err_sticky=0, err_cnt=0.
- Reset asserted mid-stream discards the in-flight word. The first valid output after reset release requires a fresh in_valid.
- Counter boundary: at err_cnt = 2^CW-1, further mismatches leave it unchanged. err and err_sticky still assert.

## Structure
- Shared package holds no types. Only the W/CW defaults are placed there if the codebase keeps width constants centrally.
- One sub-module: parity_reduce (parameter W, input [W-1:0], output 1-bit). It is a combinational XOR tree of depth ceil(log2 W).
- parity_reduce drives parity and feeds the registered stage. The top adds the registers, checker, and the counter with saturation and clr logic.

## Test plan
- Exhaustive combinational check, W=16:
  - Stimulus: a = 0..65535, 10 ns apart, no clock activity.
  - Response: parity equals the bitwise XOR reduction every time, e.g. a=16'h0000 -> 0, 16'h0001 -> 1, 16'h8001 -> 0, 16'hFFFF -> 0, 16'h7FFF -> 1.
- Registered path:
  - Stimulus: a=16'h0003 with in_valid=1, then a=16'h0007.
  - Response: after each edge, parity_q=0 then 1, odd_q=1 then 0, out_valid=1. When in_valid drops, out_valid goes 0 and parity_q holds 1.
- Checker:
  - Stimulus: a=16'h0001, parity_in=0, chk_en=1, in_valid=1.
  - Response: err=1 for one cycle, err_sticky=1, err_cnt=1. The same word with parity_in=1 gives err=0.
  - With chk_en=0 and a wrong parity_in: err stays 0.
- Saturation and clr:
  - Stimulus: CW=2, five consecutive mismatches.
  - Response: err_cnt goes 1, 2, 3, 3, 3.
  - clr together with a mismatch: err_cnt=0 and err_sticky=0, while err=1 that cycle.
- Async reset:
  - Stimulus: assert rst between clock edges while out_valid=1, err_cnt=2 and parity_q=1.
  - Response: outputs go immediately to parity_q=0, odd_q=1, out_valid=0, err=0, err_sticky=0, err_cnt=0. parity still tracks a throughout.

Source files
------------

// File: rtl/parity_gen_pkg.sv
// Width defaults shared by the parity generator and anything that instantiates it.
package parity_gen_pkg;

  localparam int DEFAULT_W  = 16;
  localparam int DEFAULT_CW = 8;

endpackage

// File: rtl/parity_gen_parity_reduce.sv
// Balanced XOR tree producing the even-parity bit of a W-bit word.
module parity_reduce #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  output logic         y
);

  localparam int DEPTH  = $clog2(W);
  localparam int LEAVES = 1 << DEPTH;

  // Leaves beyond W are tied to zero so the tree stays balanced for any W.
  for (genvar l = 0; l <= DEPTH; l++) begin : g_lvl
    logic [(LEAVES >> l)-1:0] v;
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < LEAVES; i++) begin : g_bit
        if (i < W) begin : g_real
          assign v[i] = a[i];
        end else begin : g_pad
          assign v[i] = 1'b0;
        end
      end
    end else begin : g_node
      for (genvar i = 0; i < (LEAVES >> l); i++) begin : g_bit
        assign v[i] = g_lvl[l-1].v[2*i] ^ g_lvl[l-1].v[2*i+1];
      end
    end
  end

  assign y = g_lvl[DEPTH].v[0];

endmodule

// File: rtl/parity_gen.sv
// Even-parity generator with a registered parity stage, mismatch checker
// and saturating error counter.
module parity_gen
  import parity_gen_pkg::*;
#(
  parameter int W  = DEFAULT_W,
  parameter int CW = DEFAULT_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  a,
  output logic          parity,
  input  logic          in_valid,
  input  logic          chk_en,
  input  logic          parity_in,
  input  logic          clr,
  output logic          parity_q,
  output logic          odd_q,
  output logic          out_valid,
  output logic          err,
  output logic          err_sticky,
  output logic [CW-1:0] err_cnt
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic mismatch;

  parity_reduce #(.W(W)) u_reduce (
    .a (a),
    .y (parity)
  );

  assign mismatch = in_valid & chk_en & (parity_in != parity);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q  <= 1'b0;
      odd_q     <= 1'b1;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      err       <= mismatch;
      if (in_valid) begin
        parity_q <= parity;
        odd_q    <= ~parity;
      end
    end
  end

  // clr wins over a same-cycle mismatch; err above still pulses for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (clr) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (mismatch) begin
      err_sticky <= 1'b1;
      if (err_cnt != CNT_MAX) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parity_gen.sv
// Self-checking bench for parity_gen: exhaustive combinational sweep, directed
// registered/checker/saturation/reset steps, and a randomized phase.
module tb_parity_gen;

  localparam int W  = 16;
  localparam int CW = 2;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clk_run = 1'b0;
  logic          rst;
  logic [W-1:0]  a;
  logic          parity;
  logic          in_valid;
  logic          chk_en;
  logic          parity_in;
  logic          clr;
  logic          parity_q;
  logic          odd_q;
  logic          out_valid;
  logic          err;
  logic          err_sticky;
  logic [CW-1:0] err_cnt;

  int tests  = 0;
  int failed = 0;

  logic m_parity_q, m_odd_q, m_out_valid, m_err, m_sticky;
  int   m_cnt;

  parity_gen #(.W(W), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .parity     (parity),
    .in_valid   (in_valid),
    .chk_en     (chk_en),
    .parity_in  (parity_in),
    .clr        (clr),
    .parity_q   (parity_q),
    .odd_q      (odd_q),
    .out_valid  (out_valid),
    .err        (err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  function automatic logic refParity(input logic [W-1:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_parity_q  = 1'b0;
    m_odd_q     = 1'b1;
    m_out_valid = 1'b0;
    m_err       = 1'b0;
    m_sticky    = 1'b0;
    m_cnt       = 0;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".parity"},     32'(parity),     32'(refParity(a)));
    checkOutput({tag, ".parity_q"},   32'(parity_q),   32'(m_parity_q));
    checkOutput({tag, ".odd_q"},      32'(odd_q),      32'(m_odd_q));
    checkOutput({tag, ".out_valid"},  32'(out_valid),  32'(m_out_valid));
    checkOutput({tag, ".err"},        32'(err),        32'(m_err));
    checkOutput({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_sticky));
    checkOutput({tag, ".err_cnt"},    32'(err_cnt),    32'(m_cnt));
  endtask

  // Drives one cycle of inputs, advances the reference model at the edge, checks #1 later.
  task automatic applyStimulus(input string tag, input logic [W-1:0] av, input logic iv,
                               input logic ce, input logic pin, input logic cl);
    logic p, mism;
    a = av; in_valid = iv; chk_en = ce; parity_in = pin; clr = cl;
    @(posedge clk);
    p    = refParity(av);
    mism = iv && ce && (pin != p);
    m_out_valid = iv;
    m_err       = mism;
    if (iv) begin
      m_parity_q = p;
      m_odd_q    = !p;
    end
    if (cl) begin
      m_cnt    = 0;
      m_sticky = 1'b0;
    end else if (mism) begin
      m_sticky = 1'b1;
      if (m_cnt < CNT_SAT) m_cnt++;
    end
    #1;
    checkAll(tag);
  endtask

  initial begin
    int sat_exp [5] = '{1, 2, 3, 3, 3};
    rst = 1'b1; a = '0; in_valid = 1'b0; chk_en = 1'b0; parity_in = 1'b0; clr = 1'b0;
    modelReset();
    #3;
    checkAll("reset");

    // Exhaustive combinational sweep with the clock stopped.
    for (int i = 0; i < (1 << W); i++) begin
      a = W'(i);
      #5;
      checkOutput("comb_parity", 32'(parity), 32'(refParity(a)));
      #5;
    end
    a = 16'h8001; #1; checkOutput("comb_8001", 32'(parity), 32'd0);
    a = 16'h7FFF; #1; checkOutput("comb_7FFF", 32'(parity), 32'd1);

    clk_run = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("reg_0003", 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reg_0003_pq", 32'(parity_q), 32'd0);
    applyStimulus("reg_0007", 16'h0007, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reg_0007_pq", 32'(parity_q), 32'd1);
    applyStimulus("reg_idle", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reg_idle_hold", 32'(parity_q), 32'd1);

    applyStimulus("chk_bad",  16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("chk_bad_cnt", 32'(err_cnt), 32'd1);
    applyStimulus("chk_good", 16'h0001, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("chk_good_err", 32'(err), 32'd0);
    applyStimulus("chk_off",  16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("chk_off_err", 32'(err), 32'd0);

    applyStimulus("sat_clr", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("sat", 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("sat_cnt", 32'(err_cnt), 32'(sat_exp[i]));
    end
    applyStimulus("clr_mism", 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("clr_mism_err", 32'(err), 32'd1);
    checkOutput("clr_mism_cnt", 32'(err_cnt), 32'd0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus("rand", W'($urandom), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end

    // Build up out_valid=1, err_cnt=2, parity_q=1, then reset between edges.
    applyStimulus("pre_clr", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("pre_m1",  16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus("pre_m2",  16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_cnt", 32'(err_cnt), 32'd2);
    #2;
    rst = 1'b1;
    a = 16'h00F1;
    modelReset();
    #1;
    checkAll("async_rst");
    a = 16'h00F0; in_valid = 1'b1; chk_en = 1'b1; parity_in = 1'b1;
    @(posedge clk); #1;
    checkAll("rst_held");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("post_idle",  16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("post_valid", 16'h1235, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
